shared_mul_scheduler: RTL and testbench
=======================================

SHARED_MUL_SCHEDULER -- requirements
Module: shared_mul_scheduler

Interface
REQ-001 Parameter N, default 8, operand width in bits (N >= 2).
REQ-002 Parameter R, default 4, number of requesters (power of two, 2..8); IDW = log2(R).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  R  per-requester multiply request; level; held by requester until its gnt bit is seen.
REQ-006 a_in  input  R*N  multiplier operands; lane i = bits [i*N +: N]; held stable while req[i] high.
REQ-007 b_in  input  R*N  multiplicand operands; same lane layout.
REQ-008 gnt  output  R  one-hot grant pulse; registered.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 done_id  output  IDW  index of the requester whose result is on product; valid when done=1.
REQ-012 product  output  2N  unsigned a*b of the served request; held until the next load.

Function
REQ-013 FSM states SHALL be: IDLE, GRANT, RUN, DONE.
REQ-014 IDLE: if req != 0, the round-robin winner is registered, and the state moves to GRANT; otherwise the FSM stays in IDLE.
REQ-015 Round robin: the search starts at pointer ptr and picks the first set req bit at or above ptr, wrapping modulo R.
REQ-016 After each grant, ptr SHALL become (winner+1) mod R.
REQ-017 GRANT lasts exactly one cycle, with gnt[winner]=1 and all other gnt bits 0.
REQ-018 GRANT: at the closing edge, mreg <= a_in[winner], mcand <= {N'b0, b_in[winner]} (2N wide), acc <= 0, cnt <= 0, and the state moves to RUN.
REQ-019 RUN, per cycle: if mreg[0]=1 then acc <= acc + mcand (2N-bit, no overflow possible); mcand <= mcand << 1; mreg <= mreg >> 1; cnt <= cnt + 1.
REQ-020 RUN exit: after the cycle in which cnt reaches N-1 (exactly N RUN cycles), the state moves to DONE (see REQ-029 for the alternative).
REQ-021 DONE lasts one cycle: done=1, done_id=winner, product=acc; the next state is IDLE.
REQ-022 Latency: done SHALL rise exactly N+2 cycles after the gnt cycle.
REQ-023 Throughput: at most one operation per N+3 cycles.
REQ-024 Requests arriving or changing during GRANT/RUN/DONE SHALL NOT affect the operation in flight; they are arbitrated on the next IDLE.
REQ-025 If req[winner] drops during GRANT, the operation SHALL still run on whatever a_in/b_in lanes present at the GRANT edge.
REQ-026 Outside GRANT, gnt SHALL be 0; outside DONE, done SHALL be 0.

Reset
REQ-027 On reset, asynchronously: state=IDLE; gnt=0; done=0; done_id=0; product=0; acc=0; mreg=0; mcand=0; cnt=0; ptr=0.
REQ-028 Reset mid-operation SHALL abort with no done pulse; the first post-reset request SHALL be served from ptr=0.

Configuration
REQ-029 Macro SHARED_MUL_EARLY_TERM_EN:
- Defined: RUN SHALL also exit to DONE after any RUN cycle whose next mreg value is 0.
- Defined: RUN cycle count k = max(1, position of highest set bit of a + 1), with k=1 for a=0.
- Defined: done rises k+2 cycles after gnt.
- Undefined: RUN is always N cycles, per REQ-020.
- Result values SHALL be identical in both builds.

Verification (N=8, R=4)
REQ-030 Single request: req=0001, a=13, b=11 -> gnt=0001 for one cycle; done 10 cycles after gnt (6 with EARLY_TERM); product=143, done_id=0.
REQ-031 Contention: req=1111 held, each bit dropped after its grant -> grant order 0,1,2,3; each done_id matches; exactly one gnt per operation.
REQ-032 Pointer wrap: serve req=0100; then req=0011 -> next grant to requester 0; ptr sequence 3 -> 1.
REQ-033 Full-scale operands: a=255, b=255 -> product=16'hFE01 (65025); done at +10 cycles in both builds.
REQ-034 Reset mid-RUN: reset asserted 4 cycles after gnt -> no done; all outputs 0; next req=0010, a=0, b=77 -> product=0, done_id=1; done at +3 cycles with EARLY_TERM, +10 without.
REQ-035 Late request: req[3] raised during RUN of requester 1 -> gnt[3] issued only after DONE and one IDLE cycle; in-flight product unaffected.

Source files
------------

// File: rtl/shared_mul_scheduler.sv
// Round-robin arbiter in front of one shared shift-and-add multiplier (IDLE/GRANT/RUN/DONE).
// Optional macro SHARED_MUL_EARLY_TERM_EN ends RUN once the multiplier register runs out of set bits.
module shared_mul_scheduler #(
  parameter int N = 8,
  parameter int R = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [R-1:0]     req,
  input  logic [R*N-1:0]   a_in,
  input  logic [R*N-1:0]   b_in,
  output logic [R-1:0]     gnt,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [2*N-1:0]   product,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held until gnt[i] is seen; gnt is a one-cycle
  // registered pulse during GRANT; done/done_id/product are registered off the
  // DONE state, so the done pulse lands on the cycle after DONE.

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  CNT_ONE  = 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [IDW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [R-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]     mreg_q, mreg_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [N-1:0]     a_lane [R];
  logic [N-1:0]     b_lane [R];
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             run_last;

  always_comb begin
    for (int i = 0; i < R; i++) begin
      a_lane[i] = a_in[i*N +: N];
      b_lane[i] = b_in[i*N +: N];
    end
  end

  // First set request at or above ptr, wrapping; R is a power of two so the
  // IDW-bit add wraps modulo R for free.
  always_comb begin
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < R; i++) begin
      cand = ptr_q + IDW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    run_last = (cnt_q == CNT_LAST);
`ifdef SHARED_MUL_EARLY_TERM_EN
    run_last = run_last || ((mreg_q >> 1) == '0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      winner_q  <= '0;
      ptr_q     <= '0;
      mreg_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      winner_q  <= winner_d;
      ptr_q     <= ptr_d;
      mreg_q    <= mreg_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = '0;
    winner_d  = winner_q;
    ptr_d     = ptr_q;
    mreg_d    = mreg_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          winner_d       = win_idx;
          ptr_d          = win_idx + PTR_ONE;
        end
      end
      GRANT: begin
        mreg_d  = a_lane[winner_q];
        mcand_d = {{N{1'b0}}, b_lane[winner_q]};
        acc_d   = '0;
        cnt_d   = '0;
      end
      RUN: begin
        if (mreg_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mreg_d  = mreg_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
      end
      DONE: begin
        done_d    = 1'b1;
        done_id_d = winner_q;
        product_d = acc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    state_dbg = state_q;
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule

// File: tb/tb_shared_mul_scheduler.sv
// Self-checking bench for shared_mul_scheduler (N=8, R=4): directed cases plus random traffic
// against a round-robin / a*b reference model.
module tb_shared_mul_scheduler;

  localparam int N = 8;
  localparam int R = 4;
  localparam int IDW = 2;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             reset;
  logic [R-1:0]     req;
  logic [R*N-1:0]   a_in;
  logic [R*N-1:0]   b_in;
  logic [R-1:0]     gnt;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [2*N-1:0]   product;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int g_cyc    = 0;
  int d_cyc    = 0;
  int ptr_m    = 0;

  shared_mul_scheduler #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .product(product), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: round robin from ptr, done latency from operand a
  function automatic int rr_pick(input logic [R-1:0] r);
    for (int i = 0; i < R; i++)
      if (r[(ptr_m + i) % R]) return (ptr_m + i) % R;
    return -1;
  endfunction

  function automatic int lat(input int a);
    int k;
    k = 1;
    for (int i = 0; i < N; i++) if (a[i]) k = i + 1;
`ifdef SHARED_MUL_EARLY_TERM_EN
    return k + 2;
`else
    return (k > 0) ? N + 2 : N + 2;
`endif
  endfunction

  // driver tasks
  task automatic set_lane(input int i, input int a, input int b);
    a_in[i*N +: N] = N'(a);
    b_in[i*N +: N] = N'(b);
  endtask

  task automatic expect_grant(input int exp_idx);
    int n;
    n = 0;
    while (gnt === '0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("gnt_timeout", 64'(n < BUDGET), 64'd1);
    check("gnt_onehot", 64'(gnt), (exp_idx >= 0) ? (64'd1 << exp_idx) : 64'd0);
    g_cyc = cyc;
    if (exp_idx >= 0) begin
      req[exp_idx] = 1'b0;
      ptr_m = (exp_idx + 1) % R;
    end
    @(negedge clk);
    check("gnt_pulse", 64'(gnt), 64'd0);
  endtask

  task automatic expect_done(input int exp_id, input int exp_prod, input int exp_lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      check("busy_run", 64'(busy), 64'd1);
      check("gnt_quiet", 64'(gnt), 64'd0);
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(n < BUDGET), 64'd1);
    d_cyc = cyc;
    check("done_latency", 64'(d_cyc - g_cyc), 64'(exp_lat));
    check("done_id", 64'(done_id), 64'(exp_id));
    check("product", 64'(product), 64'(exp_prod));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("product_hold", 64'(product), 64'(exp_prod));
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_done_id", 64'(done_id), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    ptr_m = 0;
    @(negedge clk);
  endtask

  initial begin
    int w, av, bv, m, ga;
    req = '0;
    a_in = '0;
    b_in = '0;
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // single request
    set_lane(0, 13, 11);
    req = 4'b0001;
    expect_grant(rr_pick(req));
    expect_done(0, 143, lat(13));

    // contention from ptr=0
    do_reset();
    for (int i = 0; i < R; i++) set_lane(i, $urandom_range(0, 255), $urandom_range(0, 255));
    req = 4'b1111;
    for (int op = 0; op < R; op++) begin
      w = rr_pick(req);
      check("rr_order", 64'(w), 64'(op));
      av = int'(a_in[w*N +: N]);
      bv = int'(b_in[w*N +: N]);
      expect_grant(w);
      expect_done(w, av * bv, lat(av));
    end

    // pointer wrap
    set_lane(2, $urandom_range(0, 255), $urandom_range(0, 255));
    req = 4'b0100;
    av = int'(a_in[2*N +: N]);
    bv = int'(b_in[2*N +: N]);
    expect_grant(rr_pick(req));
    expect_done(2, av * bv, lat(av));
    set_lane(0, $urandom_range(0, 255), $urandom_range(0, 255));
    set_lane(1, $urandom_range(0, 255), $urandom_range(0, 255));
    req = 4'b0011;
    for (int op = 0; op < 2; op++) begin
      w = rr_pick(req);
      av = int'(a_in[w*N +: N]);
      bv = int'(b_in[w*N +: N]);
      expect_grant(w);
      expect_done(w, av * bv, lat(av));
    end

    // full-scale operands
    set_lane(3, 255, 255);
    req = 4'b1000;
    expect_grant(rr_pick(req));
    expect_done(3, 65025, N + 2);

    // reset mid-RUN
    set_lane(1, $urandom_range(1, 255), $urandom_range(1, 255));
    req = 4'b0010;
    expect_grant(rr_pick(req));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done_id", 64'(done_id), 64'd0);
    reset = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 64'(done), 64'd0);
    end
    set_lane(1, 0, 77);
    req = 4'b0010;
    expect_grant(rr_pick(req));
    expect_done(1, 0, lat(0));

    // late request during RUN; in-flight lanes scrambled after grant
    av = $urandom_range(0, 255);
    bv = $urandom_range(0, 255);
    set_lane(1, av, bv);
    req = 4'b0010;
    expect_grant(rr_pick(req));
    ga = g_cyc;
    repeat (2) @(negedge clk);
    set_lane(1, 255 - av, 255 - bv);
    set_lane(3, 99, 201);
    req[3] = 1'b1;
    expect_done(1, av * bv, lat(av));
    w = rr_pick(req);
    expect_grant(w);
    check("late_gnt_id", 64'(w), 64'd3);
    check("late_gnt_gap", 64'(g_cyc - ga), 64'(lat(av) + 1));
    expect_done(3, 99 * 201, lat(99));

    // random traffic
    for (int op = 0; op < 16; op++) begin
      if (req == '0) begin
        m = $urandom_range(1, (1 << R) - 1);
        for (int i = 0; i < R; i++)
          if (m[i]) set_lane(i, $urandom_range(0, 255), $urandom_range(0, 255));
        req = R'(m);
      end
      w = rr_pick(req);
      av = int'(a_in[w*N +: N]);
      bv = int'(b_in[w*N +: N]);
      expect_grant(w);
      expect_done(w, av * bv, lat(av));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
